// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and helpers for the FIFO read-side stream stage
package fifo_pkg;

  localparam int WIDTH_DEF = 32;

  typedef logic [1:0] occ_t;

  // Ceiling log2; callers needing a non-zero width clamp the result themselves.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// rtl/stream_skid_buf.sv - 2-entry valid/ready skid buffer with a capture port
module stream_skid_buf
  import fifo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cap_valid,
  input  logic [WIDTH-1:0] cap_data,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output occ_t             occupancy
);

  logic [WIDTH-1:0] d1;
  logic             v1;
  logic             xfer;

  assign xfer      = m_valid && m_ready;
  assign occupancy = occ_t'({1'b0, m_valid}) + occ_t'({1'b0, v1});

  // Entry 0 is the output register; entry 1 only fills while entry 0 is stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_data  <= '0;
      m_valid <= 1'b0;
      d1      <= '0;
      v1      <= 1'b0;
    end else if (xfer) begin
      if (v1) begin
        m_data <= d1;
        v1     <= cap_valid;
        if (cap_valid) d1 <= cap_data;
      end else begin
        m_valid <= cap_valid;
        if (cap_valid) m_data <= cap_data;
      end
    end else if (cap_valid) begin
      if (!m_valid) begin
        m_data  <= cap_data;
        m_valid <= 1'b1;
      end else begin
        d1 <= cap_data;
        v1 <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - paces FIFO reads and frames the words into fixed-length packets
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int PKT_LEN = 16,
  parameter int CNT_W   = 16
) (
  input  logic             read_clk,
  input  logic             reset,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_read_en,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic [CNT_W-1:0] word_count,
  output logic [CNT_W-1:0] pkt_count
);

  localparam int BW = (clog2(PKT_LEN) < 1) ? 1 : clog2(PKT_LEN);
  localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

  logic          rd_pending;
  occ_t          occupancy;
  logic [BW-1:0] beat;
  logic          xfer;

  // fifo_empty lags the FIFO by a cycle, so a read is never issued right after another.
  assign fifo_read_en = reset && !fifo_empty && !rd_pending && (occupancy != 2'd2);

  stream_skid_buf #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk      (read_clk),
    .reset    (reset),
    .cap_valid(rd_pending),
    .cap_data (fifo_data),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .occupancy(occupancy)
  );

  assign xfer   = m_valid && m_ready;
  assign m_last = m_valid && (beat == LAST_BEAT);

  always_ff @(posedge read_clk or negedge reset) begin
    if (!reset) begin
      rd_pending <= 1'b0;
      beat       <= '0;
      word_count <= '0;
      pkt_count  <= '0;
    end else begin
      rd_pending <= fifo_read_en;
      if (xfer) begin
        word_count <= word_count + CNT_W'(1);
        if (m_last) begin
          beat      <= '0;
          pkt_count <= pkt_count + CNT_W'(1);
        end else begin
          beat <= beat + BW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - directed self-checking bench for fifo_stream_reader
module tb_fifo_stream_reader;

  logic        read_clk = 1'b0;
  logic        reset    = 1'b0;
  logic        m_ready  = 1'b0;

  logic        a_empty = 1'b1;
  logic [31:0] a_fdata = '0;
  logic        a_ren, a_valid, a_last;
  logic [31:0] a_data;
  logic [15:0] a_wc, a_pc;

  logic        b_empty = 1'b1;
  logic [31:0] b_fdata = '0;
  logic        b_ren, b_valid, b_last;
  logic [31:0] b_data;
  logic [3:0]  b_wc, b_pc;

  fifo_stream_reader #(.WIDTH(32), .PKT_LEN(4), .CNT_W(16)) dut_a (
    .read_clk(read_clk), .reset(reset), .fifo_empty(a_empty), .fifo_data(a_fdata),
    .fifo_read_en(a_ren), .m_data(a_data), .m_valid(a_valid), .m_ready(m_ready),
    .m_last(a_last), .word_count(a_wc), .pkt_count(a_pc)
  );

  fifo_stream_reader #(.WIDTH(32), .PKT_LEN(1), .CNT_W(4)) dut_b (
    .read_clk(read_clk), .reset(reset), .fifo_empty(b_empty), .fifo_data(b_fdata),
    .fifo_read_en(b_ren), .m_data(b_data), .m_valid(b_valid), .m_ready(m_ready),
    .m_last(b_last), .word_count(b_wc), .pkt_count(b_pc)
  );

  always #5 read_clk = ~read_clk;

  logic [31:0] q_a[$], q_b[$], out_a[$], out_b[$];
  logic        last_a[$];
  int          n_vec = 0, n_miss = 0;
  int          underflow = 0, adj = 0, ren_cnt = 0, valid_cyc = 0, lasts_b = 0;
  int          cyc = 0, first_ren = -1, first_valid = -1;
  logic        prev_ren_a = 1'b0, prev_ren_b = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FIFO models: empty flag is registered from the pre-pop fill level, so it lags by a cycle.
  always @(posedge read_clk) begin
    automatic int sa = q_a.size();
    automatic int sb = q_b.size();
    if (a_ren) begin
      if (sa == 0) underflow++;
      else a_fdata <= q_a.pop_front();
    end
    if (b_ren) begin
      if (sb == 0) underflow++;
      else b_fdata <= q_b.pop_front();
    end
    a_empty <= (sa == 0);
    b_empty <= (sb == 0);
  end

  always @(negedge read_clk) begin
    cyc++;
    if (a_ren) begin
      ren_cnt++;
      if (prev_ren_a) adj++;
      if (first_ren < 0) first_ren = cyc;
    end
    if (b_ren && prev_ren_b) adj++;
    prev_ren_a = a_ren;
    prev_ren_b = b_ren;
    if (a_valid) valid_cyc++;
    if (a_valid && first_valid < 0) first_valid = cyc;
    if (a_valid && m_ready) begin
      out_a.push_back(a_data);
      last_a.push_back(a_last);
    end
    if (b_valid && m_ready) begin
      out_b.push_back(b_data);
      if (b_last) lasts_b++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge read_clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    out_a.delete();
    last_a.delete();
    out_b.delete();
    ren_cnt = 0; valid_cyc = 0; lasts_b = 0;
    first_ren = -1; first_valid = -1;
  endtask

  task automatic rst_all();
    reset = 1'b0;
    step(2);
    q_a.delete();
    q_b.delete();
    clear_mon();
    reset = 1'b1;
    step(1);
  endtask

  function automatic logic [31:0] word_a(input int i);
    return (i < out_a.size()) ? out_a[i] : 32'hDEAD_DEAD;
  endfunction

  function automatic logic [31:0] last_mask();
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < last_a.size() && i < 32; i++) m[i] = last_a[i];
    return m;
  endfunction

  initial begin
    bit found;
    step(2);
    check("rst_ren", {31'b0, a_ren}, 32'd0);
    check("rst_valid", {31'b0, a_valid}, 32'd0);
    check("rst_counts", {a_wc, a_pc}, 32'd0);
    rst_all();

    // Basic drain at full rate
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) q_a.push_back(32'hA0 + i);
    step(20);
    check("basic_adjacent_reads", adj, 0);
    check("basic_count", out_a.size(), 4);
    for (int i = 0; i < 4; i++) check("basic_word", word_a(i), 32'hA0 + i);
    check("basic_latency", first_valid - first_ren, 2);
    check("basic_word_count", {16'b0, a_wc}, 32'd4);

    // Backpressure: two reads fill the buffer, then nothing until release
    rst_all();
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) q_a.push_back(32'hB0 + i);
    step(5);
    check("bp_hold_early", a_data, 32'hB0);
    step(15);
    check("bp_reads", ren_cnt, 2);
    check("bp_valid", {31'b0, a_valid}, 32'd1);
    check("bp_hold_late", a_data, 32'hB0);
    m_ready = 1'b1;
    step(30);
    check("bp_count", out_a.size(), 6);
    for (int i = 0; i < 6; i++) check("bp_word", word_a(i), 32'hB0 + i);

    // Framing with PKT_LEN=4; beat must be 1 after nine words
    rst_all();
    m_ready = 1'b1;
    for (int i = 0; i < 9; i++) q_a.push_back(32'hC0 + i);
    step(40);
    check("frame_last9", last_mask(), 32'h088);
    check("frame_pkt9", {16'b0, a_pc}, 32'd2);
    check("frame_words9", {16'b0, a_wc}, 32'd9);
    for (int i = 9; i < 12; i++) q_a.push_back(32'hC0 + i);
    step(20);
    check("frame_last12", last_mask(), 32'h888);
    check("frame_pkt12", {16'b0, a_pc}, 32'd3);

    // Reset one cycle after a read_en with one word buffered (counters are non-zero here)
    clear_mon();
    m_ready = 1'b0;
    q_a.push_back(32'hE0); q_a.push_back(32'hE1); q_a.push_back(32'hE2);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge read_clk);
      if (a_ren && a_valid) found = 1'b1;
    end
    check("rst_mid_setup", {31'b0, found}, 32'd1);
    @(posedge read_clk);
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_ren", {31'b0, a_ren}, 32'd0);
    check("rst_mid_valid_last", {30'b0, a_valid, a_last}, 32'd0);
    check("rst_mid_data", a_data, 32'd0);
    check("rst_mid_counts", {a_wc, a_pc}, 32'd0);
    step(2);
    clear_mon();
    reset = 1'b1;
    m_ready = 1'b1;
    step(12);
    check("rst_mid_count", out_a.size(), 1);
    check("rst_mid_next", word_a(0), 32'hE2);
    check("rst_mid_wc", {16'b0, a_wc}, 32'd1);
    check("rst_mid_pc", {16'b0, a_pc}, 32'd0);

    // FIFO runs dry mid-packet; the packet resumes when data returns
    rst_all();
    m_ready = 1'b1;
    q_a.push_back(32'hD0); q_a.push_back(32'hD1);
    step(10);
    valid_cyc = 0;
    step(30);
    check("gap_valid_low", valid_cyc, 0);
    q_a.push_back(32'hD2); q_a.push_back(32'hD3);
    step(12);
    check("gap_count", out_a.size(), 4);
    for (int i = 0; i < 4; i++) check("gap_word", word_a(i), 32'hD0 + i);
    check("gap_last", last_mask(), 32'h8);
    check("gap_pkt", {16'b0, a_pc}, 32'd1);

    // Counter wrap with CNT_W=4, PKT_LEN=1
    rst_all();
    m_ready = 1'b1;
    for (int i = 0; i < 18; i++) q_b.push_back(32'h100 + i);
    step(60);
    check("wrap_words", out_b.size(), 18);
    check("wrap_final_word", (out_b.size() == 18) ? out_b[17] : 32'hDEAD_DEAD, 32'h111);
    check("wrap_lasts", lasts_b, 18);
    check("wrap_wc", {28'b0, b_wc}, 32'd2);
    check("wrap_pc", {28'b0, b_pc}, 32'd2);

    check("adjacent_reads_total", adj, 0);
    check("fifo_underflow", underflow, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
